// File: rtl/net_pkg.sv
// Shared types and helpers for the 64-bit flit network echo endpoint.
package net_pkg;

    localparam int FLIT_W    = 64;
    localparam int KEEP_W    = 8;
    localparam int MAC_BYTES = 6;

    typedef enum logic [1:0] {
        RX   = 2'd0,
        DROP = 2'd1,
        TX   = 2'd2
    } net_echo_state_t;

    typedef struct packed {
        logic [KEEP_W-1:0] keep;
        logic [FLIT_W-1:0] data;
    } net_flit_t;

    // Outgoing flit 0: new dst (old src, B6..B11) plus first two bytes of new src (old dst B0,B1).
    function automatic logic [FLIT_W-1:0] swap_flit0(input logic [FLIT_W-1:0] hdr0,
                                                     input logic [FLIT_W-1:0] hdr1);
        return {hdr0[15:0], hdr1[31:0], hdr0[8*MAC_BYTES +: 16]};
    endfunction

    // Outgoing flit 1: remaining new-src bytes (old dst B2..B5) under the untouched upper half.
    function automatic logic [FLIT_W-1:0] swap_flit1(input logic [FLIT_W-1:0] hdr0,
                                                     input logic [FLIT_W-1:0] hdr1);
        return {hdr1[63:32], hdr0[47:16]};
    endfunction

endpackage

// File: rtl/net_flit_ram.sv
// Single packet buffer: synchronous write, asynchronous read.
module net_flit_ram
    import net_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  net_flit_t       wdata,
    input  logic [AW-1:0]   raddr,
    output net_flit_t       rdata
);

    net_flit_t mem_q [DEPTH];

    // Write port: one flit per cycle when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/net_mac_swap_echo.sv
// Store-and-forward Ethernet echo: buffers one packet, swaps dst/src MAC, sends it back.
module net_mac_swap_echo
    import net_pkg::*;
#(
    parameter int BUF_FLITS = 256,
    parameter int CNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLIT_W-1:0]  in_bits_data,
    input  logic [KEEP_W-1:0]  in_bits_keep,
    input  logic               in_bits_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLIT_W-1:0]  out_bits_data,
    output logic [KEEP_W-1:0]  out_bits_keep,
    output logic               out_bits_last,
    output logic [CNT_W-1:0]   echo_count,
    output logic [CNT_W-1:0]   drop_count
);

    localparam int PW = $clog2(BUF_FLITS);

    net_echo_state_t   state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     last_idx_q, last_idx_d;
    logic [FLIT_W-1:0] hdr0_q, hdr0_d;
    logic [FLIT_W-1:0] hdr1_q, hdr1_d;
    logic [CNT_W-1:0]  echo_q, echo_d;
    logic [CNT_W-1:0]  drop_q, drop_d;

    logic      in_fire;
    logic      out_fire;
    logic      wr_en;
    net_flit_t wr_flit;
    net_flit_t rd_flit;

    assign in_ready  = (state_q != TX) && !reset;
    assign out_valid = (state_q == TX) && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign wr_en        = in_fire && (state_q == RX);
    assign wr_flit.keep = in_bits_keep;
    assign wr_flit.data = in_bits_data;

    net_flit_ram #(
        .DEPTH (BUF_FLITS)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_flit),
        .raddr (rd_ptr_q),
        .rdata (rd_flit)
    );

    // State, pointer, header and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RX;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_idx_q <= '0;
            hdr0_q     <= '0;
            hdr1_q     <= '0;
            echo_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_idx_q <= last_idx_d;
            hdr0_q     <= hdr0_d;
            hdr1_q     <= hdr1_d;
            echo_q     <= echo_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state logic: receive into buffer, drop runts/oversize, transmit buffered packet.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        last_idx_d = last_idx_q;
        hdr0_d     = hdr0_q;
        hdr1_d     = hdr1_q;
        echo_d     = echo_q;
        drop_d     = drop_q;

        case (state_q)
            RX: begin
                if (in_fire) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PW'(0)) hdr0_d = in_bits_data;
                    if (wr_ptr_q == PW'(1)) hdr1_d = in_bits_data;
                    if (in_bits_last) begin
                        if (wr_ptr_q == '0) begin
                            drop_d   = drop_q + 1'b1;
                            wr_ptr_d = '0;
                        end else begin
                            last_idx_d = wr_ptr_q;
                            rd_ptr_d   = '0;
                            state_d    = TX;
                        end
                    end else if (wr_ptr_q == '1) begin
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (in_fire && in_bits_last) begin
                    drop_d   = drop_q + 1'b1;
                    wr_ptr_d = '0;
                    state_d  = RX;
                end
            end
            TX: begin
                if (out_fire) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == last_idx_q) begin
                        echo_d   = echo_q + 1'b1;
                        wr_ptr_d = '0;
                        state_d  = RX;
                    end
                end
            end
            default: begin
                state_d = RX;
            end
        endcase
    end

    // TX data path: header flits come from the swapped header registers, the rest straight from RAM.
    always_comb begin
        out_bits_keep = rd_flit.keep;
        out_bits_last = (rd_ptr_q == last_idx_q);
        case (rd_ptr_q)
            PW'(0):  out_bits_data = swap_flit0(hdr0_q, hdr1_q);
            PW'(1):  out_bits_data = swap_flit1(hdr0_q, hdr1_q);
            default: out_bits_data = rd_flit.data;
        endcase
    end

    assign echo_count = echo_q;
    assign drop_count = drop_q;

endmodule
